// File: rtl/alu_control.sv
// ALU operation-select decoder for KGPMini; optional SLT decode under ALU_CTRL_SLT_EN.
// Latency: 1 clock, registered outputs. Backpressure: none, one input accepted per valid cycle.
module alu_control #(
  parameter logic [4:0] NOP_CODE = 5'b11111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [4:0] alu_sel,
  output logic       out_valid,
  output logic       illegal
);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_NOT    = 5'b00101;
  localparam logic [4:0] OP_SLL    = 5'b00110;
  localparam logic [4:0] OP_SRL    = 5'b00111;
  localparam logic [4:0] OP_SRA    = 5'b01000;
  localparam logic [4:0] OP_PASS_B = 5'b01001;
`ifdef ALU_CTRL_SLT_EN
  localparam logic [4:0] OP_SLT    = 5'b01010;
`endif

  logic [4:0] dec_sel;
  logic       dec_ill;

  // Undefined encodings fall through to NOP_CODE with dec_ill raised.
  always_comb begin
    dec_sel = NOP_CODE;
    dec_ill = 1'b0;
    case (alu_op)
      3'b000: begin
        case (funct)
          6'b000000: dec_sel = OP_ADD;
          6'b000001: dec_sel = OP_SUB;
          6'b000010: dec_sel = OP_AND;
          6'b000011: dec_sel = OP_OR;
          6'b000100: dec_sel = OP_XOR;
          6'b000101: dec_sel = OP_NOT;
          6'b000110: dec_sel = OP_SLL;
          6'b000111: dec_sel = OP_SRL;
          6'b001000: dec_sel = OP_SRA;
`ifdef ALU_CTRL_SLT_EN
          6'b001001: dec_sel = OP_SLT;
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
      3'b001: begin
        case (funct[2:0])
          3'b000:  dec_sel = OP_ADD;
          3'b001:  dec_sel = OP_SUB;
          3'b010:  dec_sel = OP_AND;
          3'b011:  dec_sel = OP_OR;
          3'b100:  dec_sel = OP_XOR;
          3'b101:  dec_sel = OP_SLL;
          3'b110:  dec_sel = OP_SRL;
          default: dec_sel = OP_SRA;
        endcase
      end
      3'b010: dec_sel = OP_ADD;
      3'b011: dec_sel = OP_SUB;
      3'b100: dec_sel = OP_PASS_B;
      3'b101: begin
        case (funct[1:0])
          2'b00:   dec_sel = OP_SLL;
          2'b01:   dec_sel = OP_SRL;
          2'b10:   dec_sel = OP_SRA;
          default: dec_ill = 1'b1;
        endcase
      end
      3'b110:  dec_ill = 1'b1;
      default: dec_sel = NOP_CODE;
    endcase
  end

  // Reset wins over a simultaneous valid input; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel   <= NOP_CODE;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (in_valid) begin
      alu_sel   <= dec_sel;
      out_valid <= 1'b1;
      illegal   <= dec_ill;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Randomized self-checking bench for alu_control against a table-driven reference model.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic [4:0] alu_sel;
  logic       out_valid;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_sel = 31;
  int exp_vld = 0;
  int exp_ill = 0;

  alu_control dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .funct     (funct),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference decode from the instruction-class tables.
  function automatic void model(input int op, input int f, output int sel, output int ill);
    int imm_tbl[8] = '{0, 1, 2, 3, 4, 6, 7, 8};
    sel = 31;
    ill = 0;
    case (op)
      0: begin
        if (f <= 8) sel = f;
`ifdef ALU_CTRL_SLT_EN
        else if (f == 9) sel = 10;
`endif
        else ill = 1;
      end
      1: sel = imm_tbl[f % 8];
      2: sel = 0;
      3: sel = 1;
      4: sel = 9;
      5: if (f % 4 == 3) ill = 1; else sel = 6 + (f % 4);
      6: ill = 1;
      default: sel = 31;
    endcase
  endfunction

  task automatic cyc(input string tag, input logic r, input logic v, input int op, input int f);
    int s, il;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    alu_op   = op[2:0];
    funct    = f[5:0];
    @(posedge clk);
    if (r) begin
      exp_sel = 31; exp_vld = 0; exp_ill = 0;
    end else if (v) begin
      model(op, f, s, il);
      exp_sel = s; exp_vld = 1; exp_ill = il;
    end else begin
      exp_vld = 0;
    end
    #1;
    check({tag, ".sel"}, int'(alu_sel), exp_sel);
    check({tag, ".vld"}, int'(out_valid), exp_vld);
    check({tag, ".ill"}, int'(illegal), exp_ill);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; alu_op = 3'b000; funct = 6'b000001;
    cyc("rst0", 1'b1, 1'b1, 0, 1);
    cyc("rst1", 1'b1, 1'b1, 1, 5);

    cyc("imm_sll", 1'b0, 1'b1, 1, 6'b010101);
    cyc("nop111", 1'b0, 1'b1, 7, 6'b000101);

    for (int f = 0; f <= 8; f++) cyc("rtype", 1'b0, 1'b1, 0, f);
    cyc("rtype63", 1'b0, 1'b1, 0, 63);
    cyc("rtype9", 1'b0, 1'b1, 0, 9);

    cyc("ls", 1'b0, 1'b1, 2, int'($urandom_range(0, 63)));
    cyc("br", 1'b0, 1'b1, 3, int'($urandom_range(0, 63)));
    cyc("lui", 1'b0, 1'b1, 4, int'($urandom_range(0, 63)));
    cyc("rsvd", 1'b0, 1'b1, 6, int'($urandom_range(0, 63)));
    cyc("shr11", 1'b0, 1'b1, 5, int'($urandom_range(0, 15)) * 4 + 3);
    cyc("shr_sra", 1'b0, 1'b1, 5, 6'b101110);

    for (int i = 0; i < 3; i++) cyc("hold", 1'b0, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));

    cyc("pre_rst", 1'b0, 1'b1, 1, 3);
    cyc("mid_rst", 1'b1, 1'b1, 0, 2);
    cyc("post_rst", 1'b0, 1'b1, 0, 4);

    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
